jt89_cmd: RTL

Command encoder and write sequencer for the jt89 PSG write port. It accepts register-level requests (channel, register type, up to 10 data bits) over a valid/ready handshake and buffers them in a small FIFO. Each request is encoded into the SN76489 latch/data byte format and driven onto `wr_n`/`dout` with programmable strobe timing. It sits between a CPU/sequencer and the jt89 `wr_n`/`din` inputs.

---
 rtl/jt89_pkg.sv | 43 ++++
 rtl/jt89_cmd_fifo.sv | 57 +++++
 rtl/jt89_cmd.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/jt89_pkg.sv
// Shared register codes, FSM encoding and byte encoders for the jt89 command sequencer.
package jt89_pkg;

    localparam logic [2:0] REG_TONE0 = 3'b000;
    localparam logic [2:0] REG_VOL0  = 3'b001;
    localparam logic [2:0] REG_TONE1 = 3'b010;
    localparam logic [2:0] REG_VOL1  = 3'b011;
    localparam logic [2:0] REG_TONE2 = 3'b100;
    localparam logic [2:0] REG_VOL2  = 3'b101;
    localparam logic [2:0] REG_NOISE = 3'b110;
    localparam logic [2:0] REG_VOL3  = 3'b111;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_STB  = 2'd2;
    localparam logic [1:0] ST_GAP  = 2'd3;

    localparam logic LATCH_PREFIX = 1'b1;

    localparam int unsigned CMD_W = 13;

    typedef struct packed {
        logic [2:0] regc;
        logic [9:0] data;
    } cmd_t;

    function automatic logic is_tone(input logic [2:0] regc);
        return !regc[0] && (regc != REG_NOISE);
    endfunction

    // Noise control only has three meaningful bits; bit 3 of the nibble is forced low.
    function automatic logic [7:0] latch_byte(input logic [2:0] regc, input logic [9:0] data);
        if (regc == REG_NOISE) begin
            return {LATCH_PREFIX, regc, 1'b0, data[2:0]};
        end
        return {LATCH_PREFIX, regc, data[3:0]};
    endfunction

    function automatic logic [7:0] data_byte(input logic [9:0] data);
        return {2'b00, data[9:4]};
    endfunction

endpackage

// File: rtl/jt89_cmd_fifo.sv
// Small synchronous FIFO (2**AW entries) with full/empty flags and asynchronous reset.
module jt89_cmd_fifo #(
    parameter int unsigned AW = 2,
    parameter int unsigned DW = 13
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] wdata,
    input  logic          pop,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   cnt_q;
    logic          wr_en;
    logic          rd_en;

    assign full  = (cnt_q == (AW + 1)'(DEPTH));
    assign empty = (cnt_q == '0);
    assign wr_en = push && !full;
    assign rd_en = pop && !empty;
    assign rdata = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   cnt_q <= cnt_q + (AW + 1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW + 1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/jt89_cmd.sv
// Encodes register requests into SN76489 latch/data bytes and strobes them onto wr_n/dout.
// Optional redundant-write suppression is enabled with JT89_CMD_DEDUP_EN.
module jt89_cmd
    import jt89_pkg::*;
#(
    parameter int unsigned FIFO_AW = 2,
    parameter int unsigned WR_LEN  = 2,
    parameter int unsigned GAP_LEN = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_en,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [2:0] req_reg,
    input  logic [9:0] req_data,
    output logic       wr_n,
    output logic [7:0] dout,
    output logic       busy
);

    localparam int unsigned CNT_MAX = (WR_LEN > GAP_LEN) ? WR_LEN : GAP_LEN;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CMD_W-1:0] fifo_rdata;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wr_n_q, wr_n_d;
    logic [7:0]       dout_q, dout_d;
    logic [7:0]       byte1_q, byte1_d;
    logic             two_q, two_d;
    cmd_t             ent_q, ent_d;

    logic [7:0]       byte0;
    logic [7:0]       byte1;
    logic             two;
    logic             skip;

    assign push      = req_valid && !fifo_full;
    assign req_ready = !fifo_full;
    assign busy      = !fifo_empty || (state_q != ST_IDLE);
    assign wr_n      = wr_n_q;
    assign dout      = dout_q;

    jt89_cmd_fifo #(
        .AW (FIFO_AW),
        .DW (CMD_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata ({req_reg, req_data}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef JT89_CMD_DEDUP_EN
    // Index 3 of the tone shadow is never used: code 110 is noise, not a tone.
    logic [9:0] tone_sh_q [4];
    logic [3:0] vol_sh_q  [4];
    logic [1:0] ch;

    assign ch = ent_q.regc[2:1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                tone_sh_q[i] <= 10'h000;
                vol_sh_q[i]  <= 4'hF;
            end
        end else if (clk_en && (state_q == ST_LOAD)) begin
            if (is_tone(ent_q.regc)) begin
                tone_sh_q[ch] <= ent_q.data;
            end else if (ent_q.regc[0]) begin
                vol_sh_q[ch] <= ent_q.data[3:0];
            end
        end
    end
`endif

    always_comb begin
        byte0 = latch_byte(ent_q.regc, ent_q.data);
        byte1 = data_byte(ent_q.data);
        two   = is_tone(ent_q.regc);
        skip  = 1'b0;
`ifdef JT89_CMD_DEDUP_EN
        if (is_tone(ent_q.regc)) begin
            if (ent_q.data == tone_sh_q[ch]) begin
                skip = 1'b1;
            end else if (ent_q.data[9:4] == tone_sh_q[ch][9:4]) begin
                two = 1'b0;
            end
        end else if (ent_q.regc[0]) begin
            skip = (ent_q.data[3:0] == vol_sh_q[ch]);
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_n_d  = wr_n_q;
        dout_d  = dout_q;
        byte1_d = byte1_q;
        two_d   = two_q;
        ent_d   = ent_q;
        pop     = 1'b0;
        if (clk_en) begin
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        ent_d   = cmd_t'(fifo_rdata);
                        state_d = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (skip) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_STB;
                        wr_n_d  = 1'b0;
                        dout_d  = byte0;
                        byte1_d = byte1;
                        two_d   = two;
                        cnt_d   = '0;
                    end
                end
                ST_STB: begin
                    if (cnt_q == CNT_W'(WR_LEN - 1)) begin
                        state_d = ST_GAP;
                        wr_n_d  = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (cnt_q == CNT_W'(GAP_LEN - 1)) begin
                        cnt_d = '0;
                        if (two_q) begin
                            state_d = ST_STB;
                            wr_n_d  = 1'b0;
                            dout_d  = byte1_q;
                            two_d   = 1'b0;
                        end else if (!fifo_empty) begin
                            // Chain straight into the next request without an IDLE cycle.
                            pop     = 1'b1;
                            ent_d   = cmd_t'(fifo_rdata);
                            state_d = ST_LOAD;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            wr_n_q  <= 1'b1;
            dout_q  <= 8'h00;
            byte1_q <= 8'h00;
            two_q   <= 1'b0;
            ent_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_n_q  <= wr_n_d;
            dout_q  <= dout_d;
            byte1_q <= byte1_d;
            two_q   <= two_d;
            ent_q   <= ent_d;
        end
    end

endmodule
